// File: rtl/dmem_bus_responder_pkg.sv
// Shared definitions for the data-memory bus responder.
// Holds the access-size encodings, the FSM state type and the byte-lane helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND,
    ST_RELEASE
  } state_e;

  // Bytes touched by an access of the given size starting at the given lane.
  function automatic logic [7:0] laneMask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane[1:0];
      default: bad = |lane;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_bus_responder_if.sv
// CPU-side memory bus handshake: address, strobes, size and the responder's
// ready/fault pulses. The 64-bit tri-state data bus is carried as a plain net.
interface dmem_bus_responder_if;
  logic [31:0] address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        ready;
  logic        fault;

  modport master (
    output address, mem_read, mem_write, size,
    input  ready, fault
  );

  modport slave (
    input  address, mem_read, mem_write, size,
    output ready, fault
  );
endinterface

// File: rtl/dmem_bus_responder_lane_align.sv
// Combinational byte-lane alignment for the data memory.
// Reads: shift the stored word down to the addressed lane and zero-extend.
// Writes: shift low-aligned store data up to the lane and merge by byte mask.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [2:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic [63:0] storeData_i,
  input  logic [7:0]  mask_i,
  output logic [63:0] readData_o,
  output logic [63:0] mergedWord_o
);

  logic [63:0] shiftedWord;
  logic [63:0] shiftedStore;
  logic [63:0] sizeMask;

  // Extract the addressed field and merge new bytes into the old word.
  always_comb begin
    shiftedWord  = word_i >> {lane_i, 3'b000};
    shiftedStore = storeData_i << {lane_i, 3'b000};
    case (size_i)
      SZ_BYTE: sizeMask = 64'h0000_0000_0000_00FF;
      SZ_HALF: sizeMask = 64'h0000_0000_0000_FFFF;
      SZ_WORD: sizeMask = 64'h0000_0000_FFFF_FFFF;
      default: sizeMask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    readData_o   = shiftedWord & sizeMask;
    mergedWord_o = word_i;
    for (int b = 0; b < 8; b++) begin
      if (mask_i[b]) begin
        mergedWord_o[8*b +: 8] = shiftedStore[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_bus_responder.sv
// Data-memory responder on the LEGv8 shared memory bus.
// Latches a CPU request, waits WAIT_STATES cycles, pulses ready for one cycle,
// drives the data bus only while answering a load, and commits stores at the
// edge that ends the response cycle.
// Optional macro DMEM_ACCESS_COUNT_EN adds read_count/write_count outputs.
module dmem_bus_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  dmem_bus_responder_if.slave  bus,
`ifdef DMEM_ACCESS_COUNT_EN
  output logic [31:0]          read_count,
  output logic [31:0]          write_count,
`endif
  inout  wire  [63:0]          data
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS * 8);
  localparam logic [2:0]  WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam bit          HAS_WAIT  = (WAIT_STATES > 0);

  state_e      state_q;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        rd_q;
  logic        wr_q;
  logic [63:0] storeData_q;
  logic        reqFault_q;
  logic [2:0]  waitCnt_q;
  logic        ready_q;
  logic        fault_q;
  logic        drive_q;

  logic [63:0] mem [DEPTH_WORDS];

  logic          reqFault;
  logic          inRange;
  logic [AW-1:0] wordIdx;
  logic [63:0]   memWord;
  logic [63:0]   readData;
  logic [63:0]   memWord_d;

  // Classify the incoming request so the fault decision is latched with it.
  always_comb begin
    inRange  = (bus.address >= BASE_ADDR) && ({1'b0, bus.address} < LIMIT);
    reqFault = (bus.mem_read && bus.mem_write)
             || misaligned(bus.size, bus.address[2:0])
             || !inRange;
  end

  assign wordIdx = AW'((addr_q - BASE_ADDR) >> 3);
  assign memWord = mem[wordIdx];

  dmem_lane_align uAlign (
    .word_i       (memWord),
    .lane_i       (addr_q[2:0]),
    .size_i       (size_q),
    .storeData_i  (storeData_q),
    .mask_i       (laneMask(size_q, addr_q[2:0])),
    .readData_o   (readData),
    .mergedWord_o (memWord_d)
  );

  // Request FSM; ready, fault and bus-drive enable are registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      storeData_q <= '0;
      reqFault_q  <= 1'b0;
      waitCnt_q   <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            addr_q      <= bus.address;
            size_q      <= bus.size;
            rd_q        <= bus.mem_read;
            wr_q        <= bus.mem_write;
            storeData_q <= data;
            reqFault_q  <= reqFault;
            if (HAS_WAIT) begin
              state_q   <= ST_WAIT;
              waitCnt_q <= WAIT_INIT;
            end else begin
              state_q <= ST_RESPOND;
              ready_q <= 1'b1;
              fault_q <= reqFault;
              drive_q <= bus.mem_read;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.mem_read && !bus.mem_write) begin
            state_q <= ST_IDLE;
          end else if (waitCnt_q == 3'd0) begin
            state_q <= ST_RESPOND;
            ready_q <= 1'b1;
            fault_q <= reqFault_q;
            drive_q <= rd_q;
          end else begin
            waitCnt_q <= waitCnt_q - 3'd1;
          end
        end
        ST_RESPOND: begin
          state_q <= ST_RELEASE;
          ready_q <= 1'b0;
          fault_q <= 1'b0;
          drive_q <= 1'b0;
        end
        ST_RELEASE: begin
          if (!bus.mem_read && !bus.mem_write) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Commit a good store at the edge that ends the response cycle.
  always_ff @(posedge clock) begin
    if (!reset && state_q == ST_RESPOND && wr_q && !reqFault_q) begin
      mem[wordIdx] <= memWord_d;
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  // Count completed good accesses; faulting and aborted ones never reach here.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (state_q == ST_RESPOND && !reqFault_q) begin
      if (rd_q) read_count <= read_count + 32'd1;
      if (wr_q) write_count <= write_count + 32'd1;
    end
  end
`endif

  assign bus.ready = ready_q;
  assign bus.fault = fault_q;
  assign data      = drive_q ? (reqFault_q ? 64'h0 : readData) : 64'hz;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Self-checking bench for dmem_bus_responder.
// Instance 0 uses one wait state, instance 1 uses three (abort scenario).
// A byte-array memory model supplies expectations for the randomized phase.
module tb_dmem_bus_responder;
  import dmem_pkg::*;

  localparam int WS0 = 1;
  localparam int WS1 = 3;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dmem_bus_responder_if bus0();
  dmem_bus_responder_if bus1();

  wire  [63:0] data0;
  wire  [63:0] data1;
  logic        drv0 = 1'b0;
  logic        drv1 = 1'b0;
  logic [63:0] dout0 = '0;
  logic [63:0] dout1 = '0;

  assign data0 = drv0 ? dout0 : 64'hz;
  assign data1 = drv1 ? dout1 : 64'hz;
  pullup pu0 (data0);
  pullup pu1 (data1);

`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0] rc0, wc0, rc1, wc1;
`endif

  dmem_bus_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS0), .BASE_ADDR(32'h0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0),
`ifdef DMEM_ACCESS_COUNT_EN
    .read_count  (rc0),
    .write_count (wc0),
`endif
    .data  (data0)
  );

  dmem_bus_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS1), .BASE_ADDR(32'h0)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1),
`ifdef DMEM_ACCESS_COUNT_EN
    .read_count  (rc1),
    .write_count (wc1),
`endif
    .data  (data1)
  );

  always #5 clock = ~clock;

  int passCount = 0;
  int checkCount = 0;
  logic [7:0] refMem [0:2047];
  int goodReads = 0;
  int goodWrites = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic [63:0] wdata;
    logic        expFault;
    logic [63:0] expData;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic setBus(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [1:0] sz, input logic [63:0] wdata, input logic drv);
    if (sel == 0) begin
      bus0.address = addr; bus0.size = sz; bus0.mem_read = rd; bus0.mem_write = wr;
      dout0 = wdata; drv0 = drv;
    end else begin
      bus1.address = addr; bus1.size = sz; bus1.mem_read = rd; bus1.mem_write = wr;
      dout1 = wdata; drv1 = drv;
    end
  endtask

  task automatic setDrv(input int sel, input logic drv);
    if (sel == 0) drv0 = drv;
    else drv1 = drv;
  endtask

  function automatic logic [65:0] sampleBus(input int sel);
    if (sel == 0) return {bus0.ready, bus0.fault, data0};
    return {bus1.ready, bus1.fault, data1};
  endfunction

  // Behavioural model: byte-addressed little-endian memory of 2 KiB at address 0.
  task automatic modelOp(input logic rd, input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic [63:0] wdata, output logic expFault, output logic [63:0] expData);
    int n;
    n = 1 << sz;
    expFault = (rd && wr) || (addr % n != 0) || (addr >= 32'd2048);
    expData = '0;
    if (!expFault) begin
      for (int k = 0; k < n; k++) begin
        if (wr) refMem[addr + k] = wdata[8*k +: 8];
        else    expData[8*k +: 8] = refMem[addr + k];
      end
      if (wr) goodWrites++;
      else    goodReads++;
    end
  endtask

  // Run one bus transaction and collect what the responder did.
  task automatic applyStimulus(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [1:0] sz, input logic [63:0] wdata, input int hold,
                               output logic gotReady, output logic gotFault, output logic [63:0] rdVal,
                               output int latency, output int pulses, output logic busFloat);
    logic [65:0] s;
    gotReady = 1'b0; gotFault = 1'b0; rdVal = '0; latency = -1; pulses = 0; busFloat = 1'b1;
    @(negedge clock);
    setBus(sel, rd, wr, addr, sz, wdata, wr);
    @(posedge clock);
    #1 setDrv(sel, 1'b0);
    for (int i = 0; i < 20 && !gotReady; i++) begin
      @(negedge clock);
      s = sampleBus(sel);
      if (s[65]) begin
        gotReady = 1'b1; gotFault = s[64]; rdVal = s[63:0]; latency = i; pulses++;
        if (!rd && s[63:0] !== ONES) busFloat = 1'b0;
      end else if (s[63:0] !== ONES) begin
        busFloat = 1'b0;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      s = sampleBus(sel);
      if (s[65]) pulses++;
      if (s[63:0] !== ONES) busFloat = 1'b0;
    end
    setBus(sel, 1'b0, 1'b0, addr, sz, '0, 1'b0);
    @(negedge clock);
    s = sampleBus(sel);
    if (s[65]) pulses++;
    if (s[63:0] !== ONES) busFloat = 1'b0;
  endtask

  task automatic runChecked(input string name, input int sel, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [1:0] sz, input logic [63:0] wdata,
                            input int hold, input logic expFault, input logic [63:0] expData);
    logic gotReady, gotFault, busFloat;
    logic [63:0] rdVal;
    int latency, pulses;
    applyStimulus(sel, rd, wr, addr, sz, wdata, hold, gotReady, gotFault, rdVal, latency, pulses, busFloat);
    checkOutput({name, "/ready"}, 64'(gotReady), 64'd1);
    checkOutput({name, "/latency"}, 64'(latency), 64'((sel == 0) ? WS0 : WS1));
    checkOutput({name, "/pulses"}, 64'(pulses), 64'd1);
    checkOutput({name, "/fault"}, 64'(gotFault), 64'(expFault));
    checkOutput({name, "/busFloat"}, 64'(busFloat), 64'd1);
    if (rd && !wr) checkOutput({name, "/data"}, rdVal, expData);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic ef;
    logic [63:0] ed;
    logic [65:0] s;
    int readies;

    setBus(0, 1'b0, 1'b0, 32'h0, 2'd0, '0, 1'b0);
    setBus(1, 1'b0, 1'b0, 32'h0, 2'd0, '0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle after reset: no ready, no fault, bus released.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      s = sampleBus(0);
      checkOutput("idle/ready", 64'(s[65]), 64'd0);
      checkOutput("idle/fault", 64'(s[64]), 64'd0);
      checkOutput("idle/bus", s[63:0], ONES);
    end

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  SZ_DWORD, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  SZ_DWORD, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h13,  SZ_BYTE,  64'h5A, 1'b0, 64'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h10,  SZ_DWORD, 64'h0, 1'b0, 64'h0123_4567_5AAB_CDEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h12,  SZ_HALF,  64'h0, 1'b0, 64'h0000_0000_0000_5AAB};
    vecs[5]  = '{1'b1, 1'b0, 32'h11,  SZ_WORD,  64'h0, 1'b1, 64'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h800, SZ_DWORD, 64'h0, 1'b1, 64'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h800, SZ_DWORD, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h16,  SZ_WORD,  64'hCAFE_F00D, 1'b1, 64'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h10,  SZ_DWORD, 64'h1111_1111_1111_1111, 1'b1, 64'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h10,  SZ_DWORD, 64'h0, 1'b0, 64'h0123_4567_5AAB_CDEF};
    vecs[11] = '{1'b1, 1'b0, 32'h17,  SZ_BYTE,  64'h0, 1'b0, 64'h0000_0000_0000_0001};

    for (int v = 0; v < 12; v++) begin
      modelOp(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].sz, vecs[v].wdata, ef, ed);
      runChecked($sformatf("vec%0d", v), 0, vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].sz,
                 vecs[v].wdata, 0, vecs[v].expFault, vecs[v].expData);
    end

    // Strobe held four cycles past ready still yields a single pulse.
    modelOp(1'b1, 1'b0, 32'h10, SZ_DWORD, '0, ef, ed);
    runChecked("hold4", 0, 1'b1, 1'b0, 32'h10, SZ_DWORD, '0, 4, ef, ed);

    // Fill the first 32 words with known data before random traffic.
    for (int w = 0; w < 32; w++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      modelOp(1'b0, 1'b1, 32'(w * 8), SZ_DWORD, d, ef, ed);
      runChecked($sformatf("init%0d", w), 0, 1'b0, 1'b1, 32'(w * 8), SZ_DWORD, d, 0, ef, ed);
    end

    // Randomized traffic against the byte-array model.
    for (int t = 0; t < 60; t++) begin
      logic rd, wr;
      logic [1:0] sz;
      logic [31:0] addr;
      logic [63:0] d;
      int r;
      sz = 2'($urandom_range(3));
      r = $urandom_range(9);
      if (r == 0)      addr = 32'h800 + 32'($urandom_range(255));
      else if (r == 1) addr = 32'($urandom_range(255));
      else             addr = 32'($urandom_range(255)) & ~(32'(1 << sz) - 32'd1);
      r = $urandom_range(15);
      rd = (r < 8); wr = (r >= 8) || (r == 0);
      d = {$urandom, $urandom};
      modelOp(rd, wr, addr, sz, d, ef, ed);
      runChecked($sformatf("rand%0d", t), 0, rd, wr, addr, sz, d, $urandom_range(2), ef, ed);
    end

    // Three wait states: a store dropped during WAIT is abandoned.
    runChecked("ws3/store", 1, 1'b0, 1'b1, 32'h20, SZ_DWORD, 64'h1111_2222_3333_4444, 0, 1'b0, 64'h0);
    @(negedge clock);
    setBus(1, 1'b0, 1'b1, 32'h20, SZ_DWORD, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    @(posedge clock);
    #1 setDrv(1, 1'b0);
    @(negedge clock);
    setBus(1, 1'b0, 1'b0, 32'h20, SZ_DWORD, '0, 1'b0);
    readies = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      s = sampleBus(1);
      if (s[65]) readies++;
    end
    checkOutput("ws3/abortReady", 64'(readies), 64'd0);
    runChecked("ws3/load", 1, 1'b1, 1'b0, 32'h20, SZ_DWORD, '0, 0, 1'b0, 64'h1111_2222_3333_4444);

`ifdef DMEM_ACCESS_COUNT_EN
    checkOutput("readCount", 64'(rc0), 64'(goodReads));
    checkOutput("writeCount", 64'(wc0), 64'(goodWrites));
`endif

    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    s = sampleBus(0);
    checkOutput("postReset/ready", 64'(s[65]), 64'd0);
    checkOutput("postReset/bus", s[63:0], ONES);
`ifdef DMEM_ACCESS_COUNT_EN
    checkOutput("readCount/reset", 64'(rc0), 64'd0);
    checkOutput("writeCount/reset", 64'(wc0), 64'd0);
`endif

    // Memory contents survive reset.
    modelOp(1'b1, 1'b0, 32'h18, SZ_DWORD, '0, ef, ed);
    runChecked("retain", 0, 1'b1, 1'b0, 32'h18, SZ_DWORD, '0, 0, ef, ed);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
